lc3_decode_issue: RTL and testbench
===================================

// Module: lc3_decode_issue
// PURPOSE
// - Consumer side of the fetch interface. Sequences the fetch unit via fetch_start and
//   captures the instruction word the memory returns for the fetch address.
// - Decodes that word into the fields the fetch unit and the execute stage use:
//   opcode, offset9, nzp, register indices and sign-extended immediate.
// - Sits between instruction memory and execute. Holds the retired instruction's fields
//   stable so the fetch unit can compute the next PC from them.
// PARAMETERS
// - MEM_LAT  2  cycles from the fetch_start edge until mem_data_in is valid (1..7)
// PORTS
// - clk          in   1   single clock, rising edge
// - rst          in   1   asynchronous reset, active-high
// - run          in   1   level; start/continue execution while high
// - mem_data_in  in   16  instruction word from memory at fetch addr_out
// - exec_done    in   1   execute stage finished the issued instruction (1-cycle pulse)
// - fetch_start  out  1   1-cycle pulse to the fetch unit
// - opCode_out   out  4   IR[15:12]; drives fetch opCode_in
// - offset_out   out  9   IR[8:0]; drives fetch offset_in
// - br_nzp       out  3   IR[11:9]; drives fetch br_nzp
// - dr_out       out  3   IR[11:9], destination/source register index
// - sr1_out      out  3   IR[8:6], SR1/BaseR index; also the fetch reg_in select for JMP/JSRR
// - sr2_out      out  3   IR[2:0]
// - imm_out      out  16  sign-extended immediate (see BEHAVIOUR)
// - instr_valid  out  1   decoded fields valid, waiting for exec_done
// - halted       out  1   sticky; TRAP x25 retired or illegal opcode
// - illegal      out  1   sticky; opcode 1000 (RTI) or 1101 decoded
// BEHAVIOUR
// - Reset:
//   - All outputs are 0; the IR register is 0 (BR, nzp=000, never taken).
//   - State goes to IDLE.
//   - Reset asserted in any state aborts the instruction in flight; no partial update.
// - FSM states: IDLE, FETCH, WAIT_MEM, DECODE, ISSUE, HALT.
//   - IDLE: if run=1 go to FETCH next cycle.
//   - FETCH: fetch_start=1 for exactly this cycle.
//     - Fields from the previous IR stay stable during the pulse.
//     - Always go to WAIT_MEM.
//   - WAIT_MEM: a counter loads MEM_LAT-1 on entry and decrements each cycle.
//     - When the counter is 0 and MEM_LAT cycles have elapsed since the FETCH edge,
//       latch IR <= mem_data_in and go to DECODE.
//   - DECODE: one cycle; the output fields are registered from the new IR.
//     - Opcode 1000 or 1101: illegal<=1, halted<=1, go to HALT.
//     - Else go to ISSUE.
//   - ISSUE: instr_valid=1 until exec_done is seen; exec_done in the first ISSUE cycle
//     is accepted.
//     - On exec_done: if IR = 16'hF025, halted<=1, go to HALT.
//     - Else if run=1, go to FETCH.
//     - Else go to IDLE (fields held).
//   - HALT: terminal; only rst leaves. fetch_start and instr_valid stay 0.
// - exec_done outside ISSUE is ignored.
// - run deasserted mid-sequence is honoured only at ISSUE completion.
// - imm_out sign extension:
//   - ADD(0001)/AND(0101): SEXT(IR[4:0]).
//   - LDR(0110)/STR(0111): SEXT(IR[5:0]).
//   - JSR(0100) with IR[11]=1: SEXT(IR[10:0]).
//   - TRAP(1111): ZEXT(IR[7:0]).
//   - All others: SEXT(IR[8:0]).
// - Cycle budget per instruction: FETCH(1) + WAIT_MEM(MEM_LAT) + DECODE(1) + ISSUE(>=1).
// - Decoded outputs change only on the DECODE edge.
// TESTING
// - rst held 5 cycles then released, run=0 -> all outputs 0, state IDLE, no fetch_start.
// - run=1, MEM_LAT=2, mem_data_in=16'hE1FF (LEA R0,#-1) ->
//   - fetch_start pulses 1 cycle;
//   - 3 cycles later opCode_out=1110, offset_out=9'h1FF, dr_out=0, imm_out=16'hFFFF,
//     instr_valid=1.
// - 16'h127F (ADD R1,R1,#-1) then exec_done -> imm_out=16'hFFFF, sr1_out=1;
//   - next fetch_start exactly 1 cycle after exec_done.
// - 16'h0E05 (BRnzp #5) -> br_nzp=111, offset_out=9'h005;
//   - fields stay stable through the following fetch_start pulse.
// - 16'hF025 then exec_done -> halted=1, no further fetch_start for 20 cycles;
//   - 16'hD000 -> illegal=1 and halted=1 without waiting for exec_done.
// - rst asserted in WAIT_MEM -> outputs 0 asynchronously;
//   - after release with run=1 the first fetch_start occurs 2 cycles later.

Source files
------------

// File: rtl/lc3_decode_issue.sv
// LC-3 decode/issue stage: sequences fetch, captures the instruction word,
// decodes fields for the fetch unit and execute stage.
// Ports: clk, rst (async, active-high), run, mem_data_in[15:0], exec_done ->
//   fetch_start, opCode_out[3:0], offset_out[8:0], br_nzp[2:0], dr_out[2:0],
//   sr1_out[2:0], sr2_out[2:0], imm_out[15:0], instr_valid, halted, illegal.
module lc3_decode_issue #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] mem_data_in,
  input  logic        exec_done,
  output logic        fetch_start,
  output logic [3:0]  opCode_out,
  output logic [8:0]  offset_out,
  output logic [2:0]  br_nzp,
  output logic [2:0]  dr_out,
  output logic [2:0]  sr1_out,
  output logic [2:0]  sr2_out,
  output logic [15:0] imm_out,
  output logic        instr_valid,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_MEM, DECODE, ISSUE, HALT
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);
  localparam logic [15:0] TRAP_HALT = 16'hF025;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  op_q, op_d;
  logic [8:0]  off_q, off_d;
  logic [2:0]  nzp_q, nzp_d;
  logic [2:0]  sr1_q, sr1_d;
  logic [2:0]  sr2_q, sr2_d;
  logic [15:0] imm_q, imm_d;
  logic        halted_q, halted_d;
  logic        ill_q, ill_d;

  logic [3:0]  ir_op;
  logic        op_alu;
  logic        op_mem;
  logic        op_jsr;
  logic        op_trap;
  logic        op_bad;
  logic [15:0] imm_dec;

  assign ir_op   = ir_q[15:12];
  assign op_alu  = (ir_op == 4'b0001) || (ir_op == 4'b0101);
  assign op_mem  = (ir_op == 4'b0110) || (ir_op == 4'b0111);
  assign op_jsr  = (ir_op == 4'b0100) && ir_q[11];
  assign op_trap = (ir_op == 4'b1111);
  assign op_bad  = (ir_op == 4'b1000) || (ir_op == 4'b1101);

  // Immediate width depends on opcode; default is the 9-bit PC offset.
  always_comb begin
    imm_dec = {{7{ir_q[8]}}, ir_q[8:0]};
    unique case (1'b1)
      op_alu:  imm_dec = {{11{ir_q[4]}}, ir_q[4:0]};
      op_mem:  imm_dec = {{10{ir_q[5]}}, ir_q[5:0]};
      op_jsr:  imm_dec = {{5{ir_q[10]}}, ir_q[10:0]};
      op_trap: imm_dec = {8'h00, ir_q[7:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ir_d     = ir_q;
    op_d     = op_q;
    off_d    = off_q;
    nzp_d    = nzp_q;
    sr1_d    = sr1_q;
    sr2_d    = sr2_q;
    imm_d    = imm_q;
    halted_d = halted_q;
    ill_d    = ill_q;
    unique case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        state_d = WAIT_MEM;
        cnt_d   = CNT_INIT;
      end
      WAIT_MEM: begin
        if (cnt_q == 3'd0) begin
          ir_d    = mem_data_in;
          state_d = DECODE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DECODE: begin
        op_d  = ir_op;
        off_d = ir_q[8:0];
        nzp_d = ir_q[11:9];
        sr1_d = ir_q[8:6];
        sr2_d = ir_q[2:0];
        imm_d = imm_dec;
        if (op_bad) begin
          ill_d    = 1'b1;
          halted_d = 1'b1;
          state_d  = HALT;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (exec_done) begin
          if (ir_q == TRAP_HALT) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else if (run) begin
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HALT: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      ir_q     <= 16'h0000;
      op_q     <= 4'h0;
      off_q    <= 9'h000;
      nzp_q    <= 3'h0;
      sr1_q    <= 3'h0;
      sr2_q    <= 3'h0;
      imm_q    <= 16'h0000;
      halted_q <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ir_q     <= ir_d;
      op_q     <= op_d;
      off_q    <= off_d;
      nzp_q    <= nzp_d;
      sr1_q    <= sr1_d;
      sr2_q    <= sr2_d;
      imm_q    <= imm_d;
      halted_q <= halted_d;
      ill_q    <= ill_d;
    end
  end

  assign fetch_start = (state_q == FETCH);
  assign instr_valid = (state_q == ISSUE);
  assign opCode_out  = op_q;
  assign offset_out  = off_q;
  assign br_nzp      = nzp_q;
  assign dr_out      = nzp_q;
  assign sr1_out     = sr1_q;
  assign sr2_out     = sr2_q;
  assign imm_out     = imm_q;
  assign halted      = halted_q;
  assign illegal     = ill_q;

endmodule

// File: tb/tb_lc3_decode_issue.sv
// Randomized bench for lc3_decode_issue against a transaction-level model
// of the fetch/decode/issue sequence.
module tb_lc3_decode_issue;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] mem_data_in;
  logic        exec_done;
  logic        fetch_start;
  logic [3:0]  opCode_out;
  logic [8:0]  offset_out;
  logic [2:0]  br_nzp;
  logic [2:0]  dr_out;
  logic [2:0]  sr1_out;
  logic [2:0]  sr2_out;
  logic [15:0] imm_out;
  logic        instr_valid;
  logic        halted;
  logic        illegal;

  lc3_decode_issue #(.MEM_LAT(MEM_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .mem_data_in (mem_data_in),
    .exec_done   (exec_done),
    .fetch_start (fetch_start),
    .opCode_out  (opCode_out),
    .offset_out  (offset_out),
    .br_nzp      (br_nzp),
    .dr_out      (dr_out),
    .sr1_out     (sr1_out),
    .sr2_out     (sr2_out),
    .imm_out     (imm_out),
    .instr_valid (instr_valid),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] m_ir;
  bit          m_halt;
  bit          m_ill;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] sx(input logic [15:0] ir,
                                     input int bits);
    int v;
    v = int'(ir) & ((1 << bits) - 1);
    if (v >= (1 << (bits - 1))) v = v - (1 << bits);
    return 16'(v);
  endfunction

  function automatic logic [15:0] m_imm(input logic [15:0] ir);
    int op;
    op = int'(ir) / 4096;
    case (op)
      1, 5:    return sx(ir, 5);
      6, 7:    return sx(ir, 6);
      4:       return ir[11] ? sx(ir, 11) : sx(ir, 9);
      15:      return ir & 16'h00FF;
      default: return sx(ir, 9);
    endcase
  endfunction

  task automatic check_fields(input string tag);
    check({tag, ":op"},   opCode_out, m_ir[15:12]);
    check({tag, ":off"},  offset_out, m_ir[8:0]);
    check({tag, ":nzp"},  br_nzp,     m_ir[11:9]);
    check({tag, ":dr"},   dr_out,     m_ir[11:9]);
    check({tag, ":sr1"},  sr1_out,    m_ir[8:6]);
    check({tag, ":sr2"},  sr2_out,    m_ir[2:0]);
    check({tag, ":imm"},  imm_out,    m_imm(m_ir));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    exec_done = 1'b0;
    mem_data_in = 16'h0000;
    m_ir = 16'h0000;
    m_halt = 1'b0;
    m_ill = 1'b0;
    repeat (5) @(negedge clk);
    check("rst:fs", fetch_start, 0);
    check("rst:iv", instr_valid, 0);
    check("rst:halt", halted, 0);
    check("rst:ill", illegal, 0);
    check_fields("rst");
    rst = 1'b0;
  endtask

  // Entered on a negedge in the FETCH cycle. Leaves on the negedge of the
  // next FETCH cycle, or in HALT.
  task automatic do_instr(input logic [15:0] ir,
                          input int dly,
                          input bit run_next);
    bit bad;
    check("fs:pulse", fetch_start, 1);
    check("fs:iv", instr_valid, 0);
    check_fields("fs:hold");
    mem_data_in = 16'($urandom);
    for (int k = 1; k <= MEM_LAT + 1; k++) begin
      @(negedge clk);
      check("wait:fs", fetch_start, 0);
      check("wait:iv", instr_valid, 0);
      check("wait:op", opCode_out, m_ir[15:12]);
      check("wait:imm", imm_out, m_imm(m_ir));
      mem_data_in = (k == MEM_LAT) ? ir : 16'($urandom);
      exec_done = 1'($urandom_range(0, 1));
      run = 1'($urandom_range(0, 1));
    end
    exec_done = 1'b0;
    @(negedge clk);
    mem_data_in = 16'($urandom);
    m_ir = ir;
    bad = (ir[15:12] == 4'h8) || (ir[15:12] == 4'hD);
    if (bad) begin
      m_ill = 1'b1;
      m_halt = 1'b1;
    end
    check_fields("dec");
    check("dec:iv", instr_valid, !bad);
    check("dec:ill", illegal, m_ill);
    check("dec:halt", halted, m_halt);
    if (bad) return;
    for (int j = 0; j <= dly; j++) begin
      exec_done = (j == dly);
      run = (j == dly) ? run_next : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (j < dly) begin
        check("iss:iv", instr_valid, 1);
        check("iss:fs", fetch_start, 0);
      end
    end
    exec_done = 1'b0;
    if (ir == 16'hF025) begin
      m_halt = 1'b1;
      check("trap:halt", halted, 1);
      check("trap:iv", instr_valid, 0);
      check("trap:fs", fetch_start, 0);
    end else if (run_next) begin
      check("next:fs", fetch_start, 1);
      check("next:iv", instr_valid, 0);
    end else begin
      check("idle:iv", instr_valid, 0);
      for (int i = 0; i < 2; i++) begin
        check("idle:fs", fetch_start, 0);
        check_fields("idle");
        @(negedge clk);
      end
      check("idle:fs", fetch_start, 0);
      run = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic halt_check(input int n);
    for (int i = 0; i < n; i++) begin
      exec_done = 1'($urandom_range(0, 1));
      run = 1'b1;
      @(negedge clk);
      check("halt:fs", fetch_start, 0);
      check("halt:iv", instr_valid, 0);
      check("halt:halt", halted, 1);
      check("halt:ill", illegal, m_ill);
      check("halt:op", opCode_out, m_ir[15:12]);
    end
    exec_done = 1'b0;
  endtask

  initial begin
    logic [15:0] ir;
    rst = 1'b1;
    run = 1'b0;
    exec_done = 1'b0;
    mem_data_in = 16'h0000;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle0:fs", fetch_start, 0);
      check("idle0:iv", instr_valid, 0);
    end
    run = 1'b1;
    @(negedge clk);

    do_instr(16'hE1FF, 0, 1'b1);
    do_instr(16'h127F, 0, 1'b1);
    do_instr(16'h0E05, 2, 1'b1);
    do_instr(16'h4FFF, 1, 1'b1);
    do_instr(16'h6D60, 0, 1'b0);
    do_instr(16'hF0A3, 3, 1'b1);
    for (int n = 0; n < 40; n++) begin
      ir = 16'($urandom);
      while (ir[15:12] == 4'h8 || ir[15:12] == 4'hD || ir == 16'hF025)
        ir = 16'($urandom);
      do_instr(ir, int'($urandom_range(0, 3)),
               ($urandom_range(0, 3) != 0));
    end
    do_instr(16'hF025, 1, 1'b1);
    halt_check(20);

    do_reset();
    run = 1'b1;
    @(negedge clk);
    do_instr(16'h3001, 0, 1'b1);
    do_instr(16'hD000, 0, 1'b1);
    halt_check(5);

    do_reset();
    run = 1'b1;
    @(negedge clk);
    do_instr(16'h8123, 0, 1'b1);
    halt_check(3);

    do_reset();
    run = 1'b1;
    @(negedge clk);
    do_instr(16'h5A3F, 0, 1'b1);
    check("ar:fs", fetch_start, 1);
    @(negedge clk);
    mem_data_in = 16'h1FFF;
    #2 rst = 1'b1;
    #1;
    m_ir = 16'h0000;
    check("ar:fs0", fetch_start, 0);
    check("ar:iv0", instr_valid, 0);
    check("ar:halt0", halted, 0);
    check_fields("ar");
    @(negedge clk);
    rst = 1'b0;
    check("ar:rel_fs", fetch_start, 0);
    @(negedge clk);
    do_instr(16'h1234, 1, 1'b0);
    do_instr(16'h0402, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
